// File: rtl/pcu_pkg.sv
// Shared types and constants for the PC unit: FSM state encoding,
// instruction length and the alignment check used on redirect targets.
package pcu_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        WAIT_TRAP = 2'd2,
        HALT      = 2'd3
    } pcu_state_e;

    localparam int         ILEN_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // A target is misaligned when any of its low address bits are set.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pcu_ctrl_if.sv
// Bundle of the PC unit's redirect, trap, halt and fetch-handshake signals.
// The master modport is the PC unit itself; the slave modport is the
// surrounding core (EXU, CSR unit, IFU) that feeds it and consumes fetch PCs.
interface pcu_ctrl_if #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 64
);

    logic                 i_redir_vld;
    logic [WIDTH-1:0]     i_redir_pc;
    logic                 i_trap_vld;
    logic [WIDTH-1:0]     i_trap_pc;
    logic                 i_halt;
    logic                 i_pc_rdy;
    logic                 o_pc_vld;
    logic [WIDTH-1:0]     o_pc;
    logic                 o_misalign;
    logic [WIDTH-1:0]     o_bad_pc;
    logic                 o_halted;
    logic [CNT_WIDTH-1:0] o_fetch_cnt;

    modport master (
        input  i_redir_vld, i_redir_pc, i_trap_vld, i_trap_pc, i_halt, i_pc_rdy,
        output o_pc_vld, o_pc, o_misalign, o_bad_pc, o_halted, o_fetch_cnt
    );

    modport slave (
        output i_redir_vld, i_redir_pc, i_trap_vld, i_trap_pc, i_halt, i_pc_rdy,
        input  o_pc_vld, o_pc, o_misalign, o_bad_pc, o_halted, o_fetch_cnt
    );

endinterface

// File: rtl/pcu_ctrl_stdreg.sv
// Generic write-enabled register with an asynchronous active-low reset to a
// parameterised value. Holds the fetch PC inside the PC unit.
module stdreg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Load din when enabled, otherwise hold; reset forces the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/pcu_ctrl.sv
// Next-generation PC unit: issues fetch PCs to the IFU under valid/ready,
// applies redirects and trap vectors, traps misaligned redirect targets,
// supports halt and a post-reset boot delay, and counts accepted fetches.
module pcu_ctrl
    import pcu_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_VAL  = WIDTH'(32'h8000_0000),
    parameter int               BOOT_DELAY = 2,
    parameter int               CNT_WIDTH  = 64
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    pcu_ctrl_if.master bus
);

    localparam int BOOT_W = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

    pcu_state_e           state;
    pcu_state_e           state_nxt;
    logic [BOOT_W-1:0]    boot_cnt;
    logic                 boot_done;

    logic                 pc_vld_q;
    logic                 halted_q;
    logic                 misalign_q;
    logic [WIDTH-1:0]     bad_pc_q;
    logic [CNT_WIDTH-1:0] fetch_cnt_q;
    logic [WIDTH-1:0]     pc_q;

    logic                 active;
    logic                 take_halt;
    logic                 take_trap;
    logic                 take_redir;
    logic                 redir_bad;
    logic                 take_step;
    logic                 handshake;
    logic                 pc_wen;
    logic [WIDTH-1:0]     pc_nxt;

    assign boot_done = (boot_cnt == BOOT_W'(BOOT_DELAY));
    assign handshake = pc_vld_q && bus.i_pc_rdy;

    // State register: reset always returns the unit to BOOT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode with halt taking precedence over trap over redirect.
    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT: begin
                if (boot_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.i_halt) begin
                    state_nxt = HALT;
                end else if (bus.i_trap_vld) begin
                    state_nxt = RUN;
                end else if (bus.i_redir_vld && is_misaligned(bus.i_redir_pc[1:0])) begin
                    state_nxt = WAIT_TRAP;
                end
            end
            WAIT_TRAP: begin
                if (bus.i_halt) begin
                    state_nxt = HALT;
                end else if (bus.i_trap_vld) begin
                    state_nxt = RUN;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Per-state actions: pick the PC source and flag misaligned redirects.
    always_comb begin
        active     = (state == RUN) || (state == WAIT_TRAP);
        take_halt  = active && bus.i_halt;
        take_trap  = active && !bus.i_halt && bus.i_trap_vld;
        take_redir = (state == RUN) && !bus.i_halt && !bus.i_trap_vld && bus.i_redir_vld;
        redir_bad  = take_redir && is_misaligned(bus.i_redir_pc[1:0]);
        take_step  = (state == RUN) && !bus.i_halt && !bus.i_trap_vld && !bus.i_redir_vld
                     && handshake;
        pc_wen     = take_trap || take_redir || take_step;
        if (take_trap) begin
            pc_nxt = bus.i_trap_pc;
        end else if (take_redir) begin
            pc_nxt = bus.i_redir_pc;
        end else begin
            pc_nxt = pc_q + WIDTH'(ILEN_BYTES);
        end
    end

    // Boot delay counter advances only while waiting in BOOT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            boot_cnt <= '0;
        end else if ((state == BOOT) && !boot_done) begin
            boot_cnt <= boot_cnt + BOOT_W'(1);
        end
    end

    // Registered status outputs derived from the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_vld_q   <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_vld_q   <= (state_nxt == RUN);
            halted_q   <= (state_nxt == HALT);
            misalign_q <= redir_bad;
        end
    end

    // Capture the offending target and hold it until the next misalign.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bad_pc_q <= '0;
        end else if (redir_bad) begin
            bad_pc_q <= bus.i_redir_pc;
        end
    end

    // Count every accepted fetch request, wrapping at the counter width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_cnt_q <= '0;
        end else if (handshake) begin
            fetch_cnt_q <= fetch_cnt_q + CNT_WIDTH'(1);
        end
    end

    stdreg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_pc_reg (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .wen   (pc_wen),
        .din   (pc_nxt),
        .dout  (pc_q)
    );

    assign bus.o_pc_vld    = pc_vld_q;
    assign bus.o_pc        = pc_q;
    assign bus.o_misalign  = misalign_q;
    assign bus.o_bad_pc    = bad_pc_q;
    assign bus.o_halted    = halted_q;
    assign bus.o_fetch_cnt = fetch_cnt_q;

    logic unused_halt;
    assign unused_halt = take_halt;

endmodule

// File: tb/tb_pcu_ctrl.sv
// Scoreboard bench for pcu_ctrl: a driver issues directed then random
// stimulus, steps a behavioural reference model and queues the expected
// outputs; an independent monitor pops and compares after every clock edge.
module tb_pcu_ctrl;

    localparam int          WIDTH      = 32;
    localparam int          CNT_WIDTH  = 64;
    localparam int          BOOT_DELAY = 2;
    localparam logic [31:0] RESET_VAL  = 32'h8000_0000;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_HALT = 3;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bad;
        logic        halted;
        logic [63:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int          m_mode;
    int          m_boot_left;
    logic [31:0] m_pc;
    logic [31:0] m_bad;
    logic        m_mis;
    logic [63:0] m_cnt;

    pcu_ctrl_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    pcu_ctrl #(
        .WIDTH      (WIDTH),
        .RESET_VAL  (RESET_VAL),
        .BOOT_DELAY (BOOT_DELAY),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode      = M_BOOT;
        m_boot_left = BOOT_DELAY;
        m_pc        = RESET_VAL;
        m_bad       = 32'h0;
        m_mis       = 1'b0;
        m_cnt       = 64'h0;
    endtask

    // One clock of the reference behaviour, written from the priority rules.
    task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic tv, input logic [31:0] tpc, input logic h);
        if (m_mode == M_RUN && rdy) m_cnt = m_cnt + 1;
        m_mis = 1'b0;
        if (m_mode == M_BOOT) begin
            if (m_boot_left == 0) m_mode = M_RUN;
            else m_boot_left = m_boot_left - 1;
        end else if (m_mode == M_RUN || m_mode == M_WAIT) begin
            if (h) begin
                m_mode = M_HALT;
            end else if (tv) begin
                m_pc   = tpc;
                m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (rv) begin
                    m_pc = rpc;
                    if ((rpc % 4) != 0) begin
                        m_bad  = rpc;
                        m_mis  = 1'b1;
                        m_mode = M_WAIT;
                    end
                end else if (rdy) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                                 input logic [31:0] rpc, input logic tv,
                                 input logic [31:0] tpc, input logic h);
        exp_t e;
        @(negedge clk);
        rst_n           = rst;
        bus.i_pc_rdy    = rdy;
        bus.i_redir_vld = rv;
        bus.i_redir_pc  = rpc;
        bus.i_trap_vld  = tv;
        bus.i_trap_pc   = tpc;
        bus.i_halt      = h;
        if (!rst) model_reset();
        else model_step(rdy, rv, rpc, tv, tpc, h);
        e.vld    = (m_mode == M_RUN);
        e.pc     = m_pc;
        e.mis    = m_mis;
        e.bad    = m_bad;
        e.halted = (m_mode == M_HALT);
        e.cnt    = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.o_pc_vld !== e.vld || bus.o_pc !== e.pc || bus.o_misalign !== e.mis ||
                    bus.o_bad_pc !== e.bad || bus.o_halted !== e.halted ||
                    bus.o_fetch_cnt !== e.cnt) begin
                    errors++;
                    $display("[TB] FAIL scoreboard t=%0t: got vld=%0b pc=%h mis=%0b bad=%h halt=%0b cnt=%0d, expected vld=%0b pc=%h mis=%0b bad=%h halt=%0b cnt=%0d",
                             $time, bus.o_pc_vld, bus.o_pc, bus.o_misalign, bus.o_bad_pc,
                             bus.o_halted, bus.o_fetch_cnt, e.vld, e.pc, e.mis, e.bad,
                             e.halted, e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r_pc;
        logic [31:0] t_pc;
        bus.i_pc_rdy    = 1'b0;
        bus.i_redir_vld = 1'b0;
        bus.i_redir_pc  = '0;
        bus.i_trap_vld  = 1'b0;
        bus.i_trap_pc   = '0;
        bus.i_halt      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("reset_vld", 64'(bus.o_pc_vld), 64'd0);
        checkOutput("reset_pc", 64'(bus.o_pc), 64'(RESET_VAL));
        checkOutput("reset_misalign", 64'(bus.o_misalign), 64'd0);
        checkOutput("reset_bad_pc", 64'(bus.o_bad_pc), 64'd0);
        checkOutput("reset_halted", 64'(bus.o_halted), 64'd0);
        checkOutput("reset_cnt", bus.o_fetch_cnt, 64'd0);

        $display("[TB] boot delay and sequential fetch");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0);
            settle();
            checkOutput("boot_vld", 64'(bus.o_pc_vld), (i == 2) ? 64'd1 : 64'd0);
        end
        checkOutput("first_pc", 64'(bus.o_pc), 64'h8000_0000);
        repeat (3) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0);
            settle();
        end
        checkOutput("seq_pc", 64'(bus.o_pc), 64'h8000_000C);
        checkOutput("seq_cnt", bus.o_fetch_cnt, 64'd3);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        settle();

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            settle();
            checkOutput("stall_pc", 64'(bus.o_pc), 64'h8000_0010);
        end
        checkOutput("stall_cnt", bus.o_fetch_cnt, 64'd4);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        settle();
        checkOutput("resume_pc", 64'(bus.o_pc), 64'h8000_0014);

        $display("[TB] trap beats redirect");
        applyStimulus(1, 1, 1, 32'h8000_0100, 1, 32'h8000_0200, 0);
        settle();
        checkOutput("prio_pc", 64'(bus.o_pc), 64'h8000_0200);
        checkOutput("prio_cnt", bus.o_fetch_cnt, 64'd6);

        $display("[TB] misaligned redirect");
        applyStimulus(1, 1, 1, 32'h8000_0102, 0, 0, 0);
        settle();
        checkOutput("mis_pulse", 64'(bus.o_misalign), 64'd1);
        checkOutput("mis_bad_pc", 64'(bus.o_bad_pc), 64'h8000_0102);
        checkOutput("mis_vld", 64'(bus.o_pc_vld), 64'd0);
        applyStimulus(1, 0, 1, 32'h8000_0300, 0, 0, 0);
        settle();
        checkOutput("mis_pulse_end", 64'(bus.o_misalign), 64'd0);
        checkOutput("wait_ignore_redir", 64'(bus.o_pc), 64'h8000_0102);
        applyStimulus(1, 0, 0, 0, 1, 32'h8000_0400, 0);
        settle();
        checkOutput("trap_vld", 64'(bus.o_pc_vld), 64'd1);
        checkOutput("trap_pc", 64'(bus.o_pc), 64'h8000_0400);

        $display("[TB] wrap, halt and reset");
        applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        settle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        settle();
        checkOutput("wrap_pc", 64'(bus.o_pc), 64'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1);
        settle();
        checkOutput("halt_vld", 64'(bus.o_pc_vld), 64'd0);
        checkOutput("halt_flag", 64'(bus.o_halted), 64'd1);
        checkOutput("halt_pc", 64'(bus.o_pc), 64'd0);
        applyStimulus(1, 1, 0, 0, 1, 32'h8000_0500, 0);
        settle();
        checkOutput("halt_ignore_trap", 64'(bus.o_pc), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("async_rst_halted", 64'(bus.o_halted), 64'd0);
        checkOutput("async_rst_pc", 64'(bus.o_pc), 64'(RESET_VAL));
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            r_pc = $urandom();
            if ($urandom_range(0, 2) != 0) r_pc = {r_pc[31:2], 2'b00};
            t_pc = $urandom();
            applyStimulus($urandom_range(0, 249) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 5) == 0, r_pc, $urandom_range(0, 15) == 0,
                          t_pc, $urandom_range(0, 199) == 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
